// File: rtl/neo_spike_detector.sv
// neo_spike_detector: adaptive-threshold spike detector reading one frame of NEO values from the result memory
// Optional feature macro: NEO_THR_OVERRIDE_EN (adds thr_ext_sel/thr_ext for an external threshold)
// Ports:
//   Clk, reset        clock (rising edge), asynchronous active-low reset
//   start             begins a frame, sampled only in IDLE
//   raddr / rdata     result-memory read port, rdata combinational from raddr
//   busy / done       busy outside IDLE, done pulses one cycle at end of frame
//   thr               registered threshold of the current or last frame
//   spike_valid/ready event stream handshake
//   spike_addr/amp    event payload (sample index, NEO value)
//   spike_count       events emitted in the current or last frame
//   thr_ext_sel/thr_ext (NEO_THR_OVERRIDE_EN only) external threshold select and value
module neo_spike_detector #(
  parameter int N = 16,
  parameter int M = 16,
  parameter int K = 4,
  parameter int REFRAC = 2
) (
  input  logic                   Clk,
  input  logic                   reset,
`ifdef NEO_THR_OVERRIDE_EN
  input  logic                   thr_ext_sel,
  input  logic signed [N+8:0]    thr_ext,
`endif
  input  logic                   start,
  output logic [$clog2(M):0]     raddr,
  input  logic signed [N-1:0]    rdata,
  output logic                   busy,
  output logic                   done,
  output logic signed [N+8:0]    thr,
  output logic                   spike_valid,
  input  logic                   spike_ready,
  output logic [$clog2(M):0]     spike_addr,
  output logic signed [N-1:0]    spike_amp,
  output logic [$clog2(M):0]     spike_count
);
  localparam int LM = $clog2(M);
  localparam int AW = LM + 1;
  localparam int SW = N + LM;
  localparam int TW = N + 9;
  localparam int RW = $clog2(REFRAC + 2);
  localparam logic [2:0] IDLE = 3'd0, ACCUM = 3'd1, THRESH = 3'd2, SCAN = 3'd3, DONE = 3'd4;
  logic [2:0] state;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] mean_full;
  logic signed [TW-1:0] thr_adapt;
  logic signed [TW-1:0] thr_new;
  logic [RW-1:0] refrac;
  logic stall;
  logic hit;
  logic last;
  assign busy = state != IDLE;
  assign last = raddr == AW'(M - 1);
  assign mean_full = sum >>> LM;
  // mean of M N-bit samples fits N bits, so K*mean fits N+9 bits
  assign thr_adapt = (mean_full > 0) ? TW'(K) * TW'(mean_full) : '0;
  assign stall = spike_valid && !spike_ready;
  assign hit = state == SCAN && !stall && rdata > thr && refrac == '0;
`ifdef NEO_THR_OVERRIDE_EN
  logic ext_mode;
  assign thr_new = ext_mode ? thr_ext : thr_adapt;
  always_ff @(posedge Clk or negedge reset)
    if (!reset) ext_mode <= 1'b0;
    else if (state == IDLE && start) ext_mode <= thr_ext_sel;
`else
  assign thr_new = thr_adapt;
`endif
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      sum         <= '0;
      refrac      <= '0;
      raddr       <= '0;
      done        <= 1'b0;
      thr         <= '0;
      spike_valid <= 1'b0;
      spike_addr  <= '0;
      spike_amp   <= '0;
      spike_count <= '0;
    end else begin
      done <= 1'b0;
      if (spike_valid && spike_ready) spike_valid <= 1'b0;
      // a hit in the acceptance cycle reloads the payload and keeps the stream full
      if (hit) begin
        spike_valid <= 1'b1;
        spike_addr  <= raddr;
        spike_amp   <= rdata;
        spike_count <= spike_count + 1'b1;
      end
      case (state)
        IDLE: begin
          raddr <= '0;
          if (start) begin
            sum         <= '0;
            refrac      <= '0;
            spike_count <= '0;
`ifdef NEO_THR_OVERRIDE_EN
            state <= thr_ext_sel ? THRESH : ACCUM;
`else
            state <= ACCUM;
`endif
          end
        end
        ACCUM: begin
          sum   <= sum + SW'(rdata);
          raddr <= raddr + 1'b1;
          if (last) state <= THRESH;
        end
        THRESH: begin
          thr   <= thr_new;
          raddr <= '0;
          state <= SCAN;
        end
        SCAN: begin
          if (!stall) begin
            raddr  <= raddr + 1'b1;
            refrac <= hit ? RW'(REFRAC) : (refrac != '0 ? refrac - 1'b1 : refrac);
            if (last) state <= DONE;
          end
        end
        DONE: begin
          if (!spike_valid) begin
            done  <= 1'b1;
            raddr <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_neo_spike_detector.sv
// tb_neo_spike_detector: scoreboard bench for neo_spike_detector with a frame-level reference model
module tb_neo_spike_detector;
  localparam int N = 16;
  localparam int M = 16;
  localparam int K = 4;
  localparam int REFRAC = 2;
  typedef struct {int a; int amp;} ev_t;
  logic Clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic spike_ready = 1'b1;
  logic [4:0] raddr, spike_addr, spike_count;
  logic signed [15:0] rdata, spike_amp;
  logic busy, done, spike_valid;
  logic signed [24:0] thr;
`ifdef NEO_THR_OVERRIDE_EN
  logic thr_ext_sel = 1'b0;
  logic signed [24:0] thr_ext = '0;
`endif
  logic signed [15:0] mem [M];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int s = 0;
  int exp_thr = 0;
  int exp_cnt = 0;
  ev_t q[$];
  neo_spike_detector #(.N(N), .M(M), .K(K), .REFRAC(REFRAC)) dut (
    .Clk(Clk), .reset(reset),
`ifdef NEO_THR_OVERRIDE_EN
    .thr_ext_sel(thr_ext_sel), .thr_ext(thr_ext),
`endif
    .start(start), .raddr(raddr), .rdata(rdata), .busy(busy), .done(done), .thr(thr),
    .spike_valid(spike_valid), .spike_ready(spike_ready), .spike_addr(spike_addr),
    .spike_amp(spike_amp), .spike_count(spike_count)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  assign rdata = (raddr < 5'(M)) ? mem[raddr[3:0]] : 16'sd0;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  // reference: threshold from the frame mean, hits are samples above it more than REFRAC samples after the previous hit
  task automatic model(input bit ext, input int et);
    int sum;
    int mean;
    int lastidx;
    ev_t e;
    sum = 0;
    lastidx = -1000;
    for (int i = 0; i < M; i++) sum += mem[i];
    mean = sum / M;
    exp_thr = ext ? et : (mean > 0 ? K * mean : 0);
    exp_cnt = 0;
    for (int i = 0; i < M; i++)
      if (mem[i] > exp_thr && i - lastidx > REFRAC) begin
        lastidx = i;
        e.a = i;
        e.amp = mem[i];
        q.push_back(e);
        exp_cnt++;
      end
  endtask
  always @(negedge Clk)
    if (reset && spike_valid && spike_ready) begin
      ev_t e;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_event: got addr=%0d amp=%0d expected no event", spike_addr, spike_amp);
      end else begin
        e = q.pop_front();
        chk("ev_addr", spike_addr, e.a);
        chk("ev_amp", spike_amp, e.amp);
      end
    end
  task automatic go(input bit ext, input int et);
    model(ext, et);
`ifdef NEO_THR_OVERRIDE_EN
    thr_ext_sel = ext;
    thr_ext = 25'(et);
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    s = cyc;
  endtask
  task automatic finish_frame(input bit rnd, input int exp_lat);
    while (!done && cyc - s < 400) begin
      if (rnd) spike_ready = ($urandom % 3) != 0;
      tick();
    end
    chk("done_seen", done, 1);
    if (exp_lat >= 0) chk("latency", cyc - s, exp_lat);
    chk("thr", thr, exp_thr);
    chk("spike_count", spike_count, exp_cnt);
    chk("queue_empty", q.size(), 0);
    spike_ready = 1'b1;
    tick();
    chk("done_pulse_end", done, 0);
    chk("busy_idle", busy, 0);
  endtask
  task automatic fill(input int v);
    for (int i = 0; i < M; i++) mem[i] = 16'(v);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    fill(0);
    repeat (3) tick();
    chk("rst_raddr", raddr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_thr", thr, 0);
    chk("rst_valid", spike_valid, 0);
    chk("rst_count", spike_count, 0);
    reset = 1'b1;
    tick();
    mem[5] = 16'sd100;
    go(0, 0);
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_run", busy, 1);
    finish_frame(0, 34);
    fill(0);
    mem[3] = 16'sd1000;
    mem[4] = 16'sd1000;
    mem[6] = 16'sd1000;
    go(0, 0);
    finish_frame(0, 34);
    spike_ready = 1'b0;
    go(0, 0);
    n = 0;
    while (!spike_valid && n < 100) begin
      tick();
      n++;
    end
    chk("stall_valid", spike_valid, 1);
    for (int j = 0; j < 10; j++) begin
      chk("stall_raddr", raddr, 4);
      chk("stall_addr", spike_addr, 3);
      chk("stall_amp", spike_amp, 1000);
      tick();
    end
    spike_ready = 1'b1;
    finish_frame(0, 44);
    fill(-50);
    go(0, 0);
    finish_frame(0, 34);
    fill(7);
    mem[0] = 16'sd200;
    go(0, 0);
    finish_frame(0, 34);
    fill(0);
    mem[15] = 16'sd100;
    go(0, 0);
    finish_frame(0, -1);
    fill(0);
    mem[7] = 16'sd100;
    spike_ready = 1'b0;
    go(0, 0);
    n = 0;
    while (!spike_valid && n < 100) begin
      tick();
      n++;
    end
    chk("pre_rst_raddr", raddr, 8);
    reset = 1'b0;
    #1;
    chk("arst_raddr", raddr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_thr", thr, 0);
    chk("arst_valid", spike_valid, 0);
    chk("arst_addr", spike_addr, 0);
    chk("arst_amp", spike_amp, 0);
    chk("arst_count", spike_count, 0);
    q.delete();
    tick();
    reset = 1'b1;
    spike_ready = 1'b1;
    repeat (20) tick();
    chk("post_rst_busy", busy, 0);
    fill(0);
    mem[5] = 16'sd100;
    go(0, 0);
    finish_frame(0, 34);
`ifdef NEO_THR_OVERRIDE_EN
    go(1, 99);
    finish_frame(0, 18);
`endif
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < M; i++)
        mem[i] = ($urandom % 4 == 0) ? 16'($urandom_range(0, 5000) - 2000) : 16'($urandom_range(0, 400) - 100);
      go(0, 0);
      finish_frame(1, -1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
